// File: rtl/seq_stage_ctrl_pkg.sv
// seq_stage_ctrl_pkg: shared Y86-64 icodes, status codes and sequencer state encodings
// STEP_WAIT encoding exists only when SEQ_SINGLE_STEP_EN is defined.
package seq_stage_ctrl_pkg;
  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PC, S_HALT, S_ERR
`ifdef SEQ_SINGLE_STEP_EN
    , S_STEP
`endif
  } state_t;
  function automatic logic is_mem(input logic [3:0] icode);
    return icode inside {ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ};
  endfunction
endpackage

// File: rtl/seq_stage_ctrl_watchdog.sv
// seq_mem_watchdog: counts MEMORY cycles without ack; expired flags the last allowed cycle
// MEM_TIMEOUT = 0 disables the watchdog.
module seq_mem_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
  logic [W-1:0] count;
  assign expired = (MEM_TIMEOUT > 0) && en && (count == LAST);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (en && !expired) count <= count + 1'b1;
  end
endmodule

// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: Y86-64 SEQ stage sequencer with data-memory handshake and status tracking
// Optional single-step mode via SEQ_SINGLE_STEP_EN (adds step_i and STEP_WAIT).
module seq_stage_ctrl
  import seq_stage_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step_i,
`endif
  input  logic       run_i,
  input  logic [3:0] icode_i,
  input  logic       inst_valid_i,
  input  logic       imem_error_i,
  input  logic       mem_ack_i,
  input  logic       dmem_error_i,
  output logic       fetch_en_o,
  output logic       decode_en_o,
  output logic       exec_en_o,
  output logic       mem_req_o,
  output logic       wb_en_o,
  output logic       pc_en_o,
  output logic       retire_o,
  output logic       busy_o,
  output logic [2:0] stat_o
);
  state_t state, next;
  logic [3:0] icode_q;
  logic [2:0] stat_n;
  logic halt_pulse;
  logic expired;
  seq_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk(clk), .rst(rst), .clr(state != S_MEM), .en(state == S_MEM), .expired(expired)
  );
`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= 1'b0;
    else step_q <= step_i;
  end
`endif
  always_comb begin
    next = state;
    stat_n = stat_o;
    case (state)
      S_IDLE: next = run_i ? S_FETCH : S_IDLE;
      S_FETCH:
        if (imem_error_i) begin
          next = S_ERR;
          stat_n = STAT_ADR;
        end else if (!inst_valid_i || icode_i > ICODE_POPQ) begin
          next = S_ERR;
          stat_n = STAT_INS;
        end else if (icode_i == ICODE_HALT) begin
          next = S_HALT;
          stat_n = STAT_HLT;
        end else next = S_DECODE;
      S_DECODE: next = S_EXEC;
      S_EXEC: next = is_mem(icode_q) ? S_MEM : S_WB;
      // a late ack beats the timeout that expires in the same cycle
      S_MEM:
        if (mem_ack_i) begin
          next = dmem_error_i ? S_ERR : S_WB;
          stat_n = dmem_error_i ? STAT_ADR : stat_o;
        end else if (expired) begin
          next = S_ERR;
          stat_n = STAT_ADR;
        end
      S_WB: next = S_PC;
`ifdef SEQ_SINGLE_STEP_EN
      S_PC: next = S_STEP;
      S_STEP: next = !run_i ? S_IDLE : (step_i && !step_q) ? S_FETCH : S_STEP;
`else
      S_PC: next = run_i ? S_FETCH : S_IDLE;
`endif
      default: next = state;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      stat_o <= STAT_AOK;
      icode_q <= '0;
      halt_pulse <= 1'b0;
    end else begin
      state <= next;
      stat_o <= stat_n;
      halt_pulse <= state == S_FETCH && next == S_HALT;
      if (state == S_FETCH && next == S_DECODE) icode_q <= icode_i;
    end
  end
  assign fetch_en_o = state == S_FETCH;
  assign decode_en_o = state == S_DECODE;
  assign exec_en_o = state == S_EXEC;
  assign mem_req_o = state == S_MEM;
  assign wb_en_o = state == S_WB;
  assign pc_en_o = state == S_PC;
  assign retire_o = state == S_PC || halt_pulse;
  assign busy_o = !(state inside {S_IDLE, S_HALT, S_ERR});
endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb_seq_stage_ctrl: directed scoreboard bench for seq_stage_ctrl (MEM_TIMEOUT=4)
// Single-step checks are compiled in when SEQ_SINGLE_STEP_EN is defined.
module tb_seq_stage_ctrl;
  import seq_stage_ctrl_pkg::*;
  typedef struct {
    string name;
    logic [10:0] v;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, inst_valid = 1'b1, imem_error = 1'b0;
  logic mem_ack = 1'b0, dmem_error = 1'b0, step = 1'b0;
  logic [3:0] icode = 4'h1;
  logic fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en, retire, busy;
  logic [2:0] stat;
  exp_t sb[$];
  int tests = 0, fails = 0;
  string tname = "reset";
  always #5 clk = ~clk;
  seq_stage_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
`ifdef SEQ_SINGLE_STEP_EN
    .step_i(step),
`endif
    .run_i(run), .icode_i(icode), .inst_valid_i(inst_valid), .imem_error_i(imem_error),
    .mem_ack_i(mem_ack), .dmem_error_i(dmem_error), .fetch_en_o(fetch_en), .decode_en_o(decode_en),
    .exec_en_o(exec_en), .mem_req_o(mem_req), .wb_en_o(wb_en), .pc_en_o(pc_en), .retire_o(retire),
    .busy_o(busy), .stat_o(stat)
  );
  // expected output vector per stage letter; R = halt entry cycle
  function automatic logic [10:0] model(input byte s, input logic [2:0] st);
    logic r, b;
    r = (s == "P") || (s == "R");
    b = s inside {"F", "D", "E", "M", "W", "P", "S"};
    return {s == "F", s == "D", s == "E", s == "M", s == "W", s == "P", r, b, st};
  endfunction
  task automatic cyc(input byte s, input logic [2:0] st);
    exp_t e;
    e.name = $sformatf("%s/%c", tname, s);
    e.v = model(s, st);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input string n);
    tname = n;
    run = 1'b0; mem_ack = 1'b0; dmem_error = 1'b0; imem_error = 1'b0; inst_valid = 1'b1; step = 1'b0;
    rst = 1'b1;
    cyc("I", STAT_AOK);
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [10:0] act;
      e = sb.pop_front();
      act = {fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en, retire, busy, stat};
      tests++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL %s: got %b required %b (f d e m w p ret busy stat)", e.name, act, e.v);
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset("nop");
    run = 1'b1; icode = ICODE_NOP;
    cyc("I", STAT_AOK); cyc("F", STAT_AOK); cyc("D", STAT_AOK); cyc("E", STAT_AOK);
    cyc("W", STAT_AOK); cyc("P", STAT_AOK);
`ifdef SEQ_SINGLE_STEP_EN
    cyc("S", STAT_AOK);
`else
    cyc("F", STAT_AOK);
`endif
    do_reset("mrmovq");
    run = 1'b1; icode = ICODE_MRMOVQ;
    cyc("I", STAT_AOK); cyc("F", STAT_AOK); cyc("D", STAT_AOK); cyc("E", STAT_AOK);
    cyc("M", STAT_AOK); cyc("M", STAT_AOK);
    mem_ack = 1'b1; cyc("M", STAT_AOK);
    mem_ack = 1'b0; cyc("W", STAT_AOK);
    run = 1'b0; cyc("P", STAT_AOK); cyc("I", STAT_AOK);
    do_reset("halt");
    run = 1'b1; icode = ICODE_HALT;
    cyc("I", STAT_AOK); cyc("F", STAT_AOK); cyc("R", STAT_HLT);
    cyc("H", STAT_HLT); cyc("H", STAT_HLT); cyc("H", STAT_HLT);
    do_reset("bad_icode");
    run = 1'b1; icode = 4'hC;
    cyc("I", STAT_AOK); cyc("F", STAT_AOK); cyc("X", STAT_INS); cyc("X", STAT_INS);
    do_reset("imem_err");
    run = 1'b1; icode = 4'hC; imem_error = 1'b1;
    cyc("I", STAT_AOK); cyc("F", STAT_AOK);
    imem_error = 1'b0; cyc("X", STAT_ADR); cyc("X", STAT_ADR);
    do_reset("not_valid");
    run = 1'b1; icode = ICODE_NOP; inst_valid = 1'b0;
    cyc("I", STAT_AOK); cyc("F", STAT_AOK); cyc("X", STAT_INS);
    do_reset("timeout");
    run = 1'b1; icode = ICODE_PUSHQ;
    cyc("I", STAT_AOK); cyc("F", STAT_AOK); cyc("D", STAT_AOK); cyc("E", STAT_AOK);
    cyc("M", STAT_AOK); cyc("M", STAT_AOK); cyc("M", STAT_AOK); cyc("M", STAT_AOK);
    cyc("X", STAT_ADR); cyc("X", STAT_ADR);
    do_reset("ack_at_timeout");
    run = 1'b1; icode = ICODE_PUSHQ;
    cyc("I", STAT_AOK); cyc("F", STAT_AOK); cyc("D", STAT_AOK); cyc("E", STAT_AOK);
    cyc("M", STAT_AOK); cyc("M", STAT_AOK); cyc("M", STAT_AOK);
    mem_ack = 1'b1; cyc("M", STAT_AOK);
    mem_ack = 1'b0; cyc("W", STAT_AOK);
    run = 1'b0; cyc("P", STAT_AOK); cyc("I", STAT_AOK);
    do_reset("dmem_err");
    run = 1'b1; icode = ICODE_CALL;
    cyc("I", STAT_AOK); cyc("F", STAT_AOK); cyc("D", STAT_AOK); cyc("E", STAT_AOK);
    mem_ack = 1'b1; dmem_error = 1'b1; cyc("M", STAT_AOK);
    mem_ack = 1'b0; dmem_error = 1'b0; cyc("X", STAT_ADR); cyc("X", STAT_ADR);
    do_reset("rst_mid_mem");
    run = 1'b1; icode = ICODE_POPQ;
    cyc("I", STAT_AOK); cyc("F", STAT_AOK); cyc("D", STAT_AOK); cyc("E", STAT_AOK);
    cyc("M", STAT_AOK);
    rst = 1'b1; cyc("I", STAT_AOK);
    rst = 1'b0; run = 1'b0; cyc("I", STAT_AOK); cyc("I", STAT_AOK);
`ifdef SEQ_SINGLE_STEP_EN
    do_reset("step");
    run = 1'b1; icode = ICODE_NOP;
    cyc("I", STAT_AOK); cyc("F", STAT_AOK); cyc("D", STAT_AOK); cyc("E", STAT_AOK);
    cyc("W", STAT_AOK); cyc("P", STAT_AOK); cyc("S", STAT_AOK); cyc("S", STAT_AOK);
    step = 1'b1; cyc("S", STAT_AOK);
    cyc("F", STAT_AOK); cyc("D", STAT_AOK); cyc("E", STAT_AOK); cyc("W", STAT_AOK);
    cyc("P", STAT_AOK);
    run = 1'b0; cyc("S", STAT_AOK); cyc("I", STAT_AOK);
`endif
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d checks left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
